// File: rtl/vga_pkg.sv
// Shared definitions for the VGA framebuffer arbiter: default widths, frame size
// and the scanout state encoding.
package vga_pkg;

  localparam int ADDR_W_DEF       = 16;
  localparam int DATA_W_DEF       = 4;
  localparam int FRAME_PIXELS_DEF = 19200;

  typedef enum logic [1:0] {
    SCAN_IDLE = 2'd0,
    SCAN_RUN  = 2'd1,
    SCAN_DONE = 2'd2
  } scan_state_t;

endpackage

// File: rtl/vga_pix_fifo.sv
// Small synchronous pixel FIFO with flush; head data is shown combinationally
// and forced to zero while the FIFO is empty.
module vga_pix_fifo
  import vga_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_flush,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_rdata,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_push;
  logic              w_pop;
  logic              w_empty;

  assign w_empty = (r_count == '0);
  assign w_push  = i_push && !i_flush;
  assign w_pop   = i_pop && !i_flush && !w_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; stale entries are never visible past o_empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = w_empty;

endmodule

// File: rtl/vga_fb_arbiter.sv
// Shares one single-port framebuffer RAM between VGA scanout prefetch and a writer port.
// Define VGA_FB_STARVE_GUARD_EN to let a long-waiting writer override low-water scan priority.
module vga_fb_arbiter
  import vga_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int FRAME_PIXELS = FRAME_PIXELS_DEF,
  parameter int FIFO_DEPTH   = 16,
  parameter int LOW_WATER    = 4,
  parameter int WR_MAX_WAIT  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              pix_pop,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_empty,
  output logic              underflow,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int                CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0]  DEPTH_L   = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  LOW_L     = CNT_W'(LOW_WATER);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);

  scan_state_t       r_state;
  logic [ADDR_W-1:0] r_scan_addr;
  logic              r_inflight;
  logic              r_underflow;

  logic [CNT_W-1:0]  w_count;
  logic [CNT_W-1:0]  w_level;
  logic              w_empty;
  logic              w_scan_want;
  logic              w_scan_low;
  logic              w_wr_force;
  logic              w_scan_grant;
  logic              w_wr_grant;

  vga_pix_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (frame_start),
    .i_push  (r_inflight),
    .i_wdata (mem_rdata),
    .i_pop   (pix_pop),
    .o_rdata (pix_data),
    .o_count (w_count),
    .o_empty (w_empty)
  );

  // The in-flight read already owns a FIFO slot, so it counts toward the level.
  assign w_level     = w_count + {{(CNT_W-1){1'b0}}, r_inflight};
  assign w_scan_want = (r_state == SCAN_RUN) && (w_level < DEPTH_L) && !frame_start;
  assign w_scan_low  = (w_level <= LOW_L);

`ifdef VGA_FB_STARVE_GUARD_EN
  localparam int               WAIT_W = $clog2(WR_MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_L = WAIT_W'(WR_MAX_WAIT);

  logic [WAIT_W-1:0] r_wait_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else if (wr_valid && !w_wr_grant) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end else begin
      r_wait_cnt <= '0;
    end
  end

  assign w_wr_force = (r_wait_cnt == WAIT_L);
`else
  // Guard disabled: the writer is never forced ahead of a low-water scan.
  assign w_wr_force = (WR_MAX_WAIT < 0);
`endif

  always_comb begin
    w_scan_grant = 1'b0;
    w_wr_grant   = 1'b0;
    if (w_scan_want && w_scan_low && !w_wr_force) begin
      w_scan_grant = 1'b1;
    end else if (wr_valid) begin
      w_wr_grant = 1'b1;
    end else if (w_scan_want) begin
      w_scan_grant = 1'b1;
    end
  end

  assign mem_en    = w_scan_grant || w_wr_grant;
  assign mem_we    = w_wr_grant;
  assign mem_addr  = w_wr_grant ? wr_addr : (w_scan_grant ? r_scan_addr : '0);
  assign mem_wdata = w_wr_grant ? wr_data : '0;
  assign wr_ready  = w_wr_grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= SCAN_IDLE;
      r_scan_addr <= '0;
      r_inflight  <= 1'b0;
    end else begin
      r_inflight <= w_scan_grant;
      if (frame_start) begin
        r_state     <= SCAN_RUN;
        r_scan_addr <= '0;
      end else if (w_scan_grant) begin
        r_scan_addr <= r_scan_addr + 1'b1;
        if (r_scan_addr == LAST_ADDR) r_state <= SCAN_DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_underflow <= 1'b0;
    end else if (frame_start) begin
      r_underflow <= 1'b0;
    end else if (pix_pop && w_empty) begin
      r_underflow <= 1'b1;
    end
  end

  assign pix_empty = w_empty;
  assign underflow = r_underflow;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter: directed vector table, corner sequences
// and randomized traffic checked against a queue-based reference model.
module tb_vga_fb_arbiter;

  localparam int FP    = 20;
  localparam int DEPTH = 16;
  localparam int LW    = 4;
  localparam int MW    = 8;

  logic        clk;
  logic        rst_n;
  logic        frame_start;
  logic        pix_pop;
  logic [3:0]  pix_data;
  logic        pix_empty;
  logic        underflow;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_addr;
  logic [3:0]  wr_data;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [3:0]  mem_wdata;
  logic [3:0]  mem_rdata;

  vga_fb_arbiter #(
    .ADDR_W       (16),
    .DATA_W       (4),
    .FRAME_PIXELS (FP),
    .FIFO_DEPTH   (DEPTH),
    .LOW_WATER    (LW),
    .WR_MAX_WAIT  (MW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .pix_pop     (pix_pop),
    .pix_data    (pix_data),
    .pix_empty   (pix_empty),
    .underflow   (underflow),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Framebuffer RAM with one-cycle registered read.
  logic [3:0] ram [0:65535];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  function automatic logic [3:0] pat(input int a);
    return 4'(a * 7 + 3);
  endfunction

  int n_chk  = 0;
  int n_pass = 0;
  int cyc_n  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc_n, act, exp);
  endtask

  // Reference model: scan progress, FIFO contents as a queue, one outstanding read.
  int         m_state;   // 0 idle, 1 running, 2 frame done
  int         m_addr;
  logic [3:0] q[$];
  bit         m_inf;
  int         m_inf_addr;
  bit         m_uf;
  int         m_wait;
  bit         e_scan;
  bit         e_wr;

  task automatic model_reset();
    m_state = 0; m_addr = 0; q.delete(); m_inf = 0; m_inf_addr = 0; m_uf = 0; m_wait = 0;
    e_scan = 0; e_wr = 0;
  endtask

  task automatic cyc(input bit fs, input bit pop, input bit wv,
                     input logic [15:0] wa, input logic [3:0] wd);
    int   level;
    bit   want;
    bit   urgent;
    bit   force_w;
    logic [15:0] ea;
    @(negedge clk);
    frame_start = fs; pix_pop = pop; wr_valid = wv; wr_addr = wa; wr_data = wd;
    #2;
    level   = q.size() + int'(m_inf);
    want    = (m_state == 1) && (level < DEPTH) && !fs;
    urgent  = want && (level <= LW);
    force_w = 1'b0;
`ifdef VGA_FB_STARVE_GUARD_EN
    force_w = (m_wait == MW);
`endif
    e_scan = 0; e_wr = 0;
    if (urgent && !force_w) e_scan = 1;
    else if (wv)            e_wr = 1;
    else if (want)          e_scan = 1;
    ea = e_wr ? wa : (e_scan ? 16'(m_addr) : 16'h0);
    chk("mem_en",    32'(mem_en),    32'(e_scan | e_wr));
    chk("mem_we",    32'(mem_we),    32'(e_wr));
    chk("mem_addr",  32'(mem_addr),  32'(ea));
    chk("mem_wdata", 32'(mem_wdata), 32'(e_wr ? wd : 4'h0));
    chk("wr_ready",  32'(wr_ready),  32'(e_wr));
    chk("pix_data",  32'(pix_data),  32'((q.size() > 0) ? q[0] : 4'h0));
    chk("pix_empty", 32'(pix_empty), 32'(q.size() == 0));
    chk("underflow", 32'(underflow), 32'(m_uf));
    if (fs) begin
      q.delete(); m_uf = 0; m_state = 1; m_addr = 0; m_inf = 0;
    end else begin
      if (pop) begin
        if (q.size() > 0) void'(q.pop_front());
        else m_uf = 1;
      end
      if (m_inf) q.push_back(pat(m_inf_addr));
      m_inf = e_scan;
      if (e_scan) begin
        m_inf_addr = m_addr;
        m_addr++;
        if (m_addr == FP) m_state = 2;
      end
    end
    m_wait = (wv && !e_wr) ? m_wait + 1 : 0;
    cyc_n++;
  endtask

  typedef struct {
    bit          fs;
    bit          pop;
    bit          wv;
    logic [15:0] wa;
    logic [3:0]  wd;
    bit          e_en;
    bit          e_we;
    logic [15:0] e_addr;
    bit          e_rdy;
  } vec_t;

  vec_t tbl [22];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          rdy_cnt;
    int          rdy_first;
    bit          drained;
    bit          pv;
    logic [15:0] pa;
    logic [3:0]  pd;
    int          pp;

    // Directed table: writer before any frame, frame_start with a write, 16 prefetch reads.
    tbl[0]  = '{1'b0, 1'b0, 1'b1, 16'h0100, 4'h5, 1'b1, 1'b1, 16'h0100, 1'b1};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 4'h0, 1'b0, 1'b0, 16'h0000, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 16'h0101, 4'h9, 1'b1, 1'b1, 16'h0101, 1'b1};
    for (int i = 0; i < 16; i++)
      tbl[3 + i] = '{1'b0, 1'b0, 1'b0, 16'h0000, 4'h0, 1'b1, 1'b0, 16'(i), 1'b0};
    tbl[19] = '{1'b0, 1'b0, 1'b0, 16'h0000, 4'h0, 1'b0, 1'b0, 16'h0000, 1'b0};
    tbl[20] = '{1'b0, 1'b0, 1'b1, 16'h0102, 4'hc, 1'b1, 1'b1, 16'h0102, 1'b1};
    tbl[21] = '{1'b0, 1'b0, 1'b0, 16'h0000, 4'h0, 1'b0, 1'b0, 16'h0000, 1'b0};

    for (int a = 0; a < 65536; a++) ram[a] = (a < 256) ? pat(a) : 4'h0;
    mem_rdata = 4'h0;
    rst_n = 1'b0; frame_start = 1'b0; pix_pop = 1'b0; wr_valid = 1'b0;
    wr_addr = 16'h0; wr_data = 4'h0;
    model_reset();

    repeat (2) @(negedge clk);
    #2;
    chk("rst_mem_en",    32'(mem_en),    32'd0);
    chk("rst_mem_we",    32'(mem_we),    32'd0);
    chk("rst_mem_addr",  32'(mem_addr),  32'd0);
    chk("rst_wr_ready",  32'(wr_ready),  32'd0);
    chk("rst_pix_data",  32'(pix_data),  32'd0);
    chk("rst_pix_empty", 32'(pix_empty), 32'd1);
    chk("rst_underflow", 32'(underflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset released at cycle %0d", cyc_n);

    for (int i = 0; i < 22; i++) begin
      cyc(tbl[i].fs, tbl[i].pop, tbl[i].wv, tbl[i].wa, tbl[i].wd);
      chk("tbl_en",   32'(mem_en),   32'(tbl[i].e_en));
      chk("tbl_we",   32'(mem_we),   32'(tbl[i].e_we));
      chk("tbl_addr", 32'(mem_addr), 32'(tbl[i].e_addr));
      chk("tbl_rdy",  32'(wr_ready), 32'(tbl[i].e_rdy));
      $display("vec %0d fs=%0b wv=%0b -> en=%0b we=%0b addr=%0h rdy=%0b",
               i, tbl[i].fs, tbl[i].wv, mem_en, mem_we, mem_addr, wr_ready);
    end

    // Drain the whole 20-pixel frame in order, then pop once more past the end.
    for (int i = 0; i < FP; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
      chk("seqA_pix", 32'(pix_data), 32'(pat(i)));
    end
    cyc(1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
    chk("seqA_empty", 32'(pix_empty), 32'd1);
    chk("seqA_done_idle", 32'(mem_en), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 16'h0, 4'h0);
    chk("seqA_underflow", 32'(underflow), 32'd1);
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 4'h0);
    cyc(1'b0, 1'b0, 1'b0, 16'h0, 4'h0);
    chk("seqA_uf_clear", 32'(underflow), 32'd0);
    chk("seqA_restart_en", 32'(mem_en), 32'd1);
    chk("seqA_restart_addr", 32'(mem_addr), 32'd0);
    $display("seqA frame end / underflow / restart done at cycle %0d", cyc_n);

    // frame_start while a read returns and a pop is requested.
    cyc(1'b0, 1'b0, 1'b0, 16'h0, 4'h0);
    cyc(1'b1, 1'b1, 1'b0, 16'h0, 4'h0);
    cyc(1'b0, 1'b0, 1'b0, 16'h0, 4'h0);
    chk("seqB_flushed", 32'(pix_empty), 32'd1);
    chk("seqB_uf", 32'(underflow), 32'd0);
    chk("seqB_addr", 32'(mem_addr), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 16'h0, 4'h0);
    chk("seqB_dropped", 32'(pix_empty), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 16'h0, 4'h0);
    chk("seqB_refill", 32'(pix_data), 32'(pat(0)));
    $display("seqB flush with return and pop done at cycle %0d", cyc_n);

    // Writer held valid while scanout stays at or below low water.
    cyc(1'b1, 1'b1, 1'b1, 16'h9000, 4'h3);
    chk("seqC_fs_write", 32'(wr_ready), 32'd1);
    rdy_cnt = 0; rdy_first = 0;
    for (int k = 1; k <= 18; k++) begin
      cyc(1'b0, 1'b1, 1'b1, 16'h9001, 4'h6);
      if (wr_ready) begin
        rdy_cnt++;
        if (rdy_first == 0) rdy_first = k;
      end
    end
`ifdef VGA_FB_STARVE_GUARD_EN
    chk("seqC_ready_count", 32'(rdy_cnt), 32'd2);
    chk("seqC_first_ready", 32'(rdy_first), 32'd9);
`else
    chk("seqC_ready_count", 32'(rdy_cnt), 32'd0);
    chk("seqC_first_ready", 32'(rdy_first), 32'd0);
`endif
    drained = 1'b0;
    for (int k = 0; k < 12 && !drained; k++) begin
      cyc(1'b0, 1'b1, 1'b1, 16'h9001, 4'h6);
      if (wr_ready) drained = 1'b1;
    end
    chk("seqC_writer_served", 32'(drained), 32'd1);
    $display("seqC writer under low water: %0d grants, first at %0d", rdy_cnt, rdy_first);

    // Randomized traffic against the reference model.
    pv = 1'b0; pa = 16'h8000; pd = 4'h0;
    for (int n = 0; n < 1600; n++) begin
      case ((n / 400) % 4)
        0:       pp = 10;
        1:       pp = 50;
        2:       pp = 90;
        default: pp = 100;
      endcase
      if (!pv && ($urandom_range(0, 1) == 1)) begin
        pv = 1'b1;
        pa = 16'h8000 | 16'($urandom_range(0, 32767));
        pd = 4'($urandom_range(0, 15));
      end
      cyc(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < pp), pv, pa, pd);
      if (e_wr) pv = 1'b0;
    end
    $display("random phase done at cycle %0d", cyc_n);

    // Asynchronous reset while reads are in flight.
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 4'h0);
    cyc(1'b0, 1'b0, 1'b0, 16'h0, 4'h0);
    cyc(1'b0, 1'b0, 1'b0, 16'h0, 4'h0);
    @(negedge clk);
    frame_start = 1'b0; pix_pop = 1'b0; wr_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_en",    32'(mem_en),    32'd0);
    chk("mid_rst_empty", 32'(pix_empty), 32'd1);
    chk("mid_rst_data",  32'(pix_data),  32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b0, 16'h0, 4'h0);
    $display("mid-access reset done at cycle %0d", cyc_n);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
